bound_monitor: RTL and testbench
================================

BOUND_MONITOR -- requirements
Module: bound_monitor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock, shared with the LED bar driver.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 LED  input  16  LED bar under observation; legal values are thermometer codes 2^L-1, L = 0..15.
REQ-005 flick  input  1  the flick request seen by the driver, sampled on the same edge as LED.
REQ-006 level  output  4  decoded lit-LED count L.
REQ-007 phase  output  2  monitor state: 00 STOP, 01 IDLE, 10 UP, 11 DOWN.
REQ-008 step  output  3  current step index, 0..5.
REQ-009 seg_done  output  1  one-cycle pulse when a bound is reached and the direction reverses.
REQ-010 seq_done  output  1  one-cycle pulse when step 5 reaches level 0.
REQ-011 err  output  1  one-cycle pulse when a protocol violation is detected.
REQ-012 err_code  output  2  cause of the last error, held until the next error or reset: 01 NOT_THERMO, 10 JUMP, 11 BAD_HOLD.

Function
REQ-013 The decoder SHALL be combinational on the input; all outputs SHALL be registered, so latency from LED change to outputs is 1 clk.
REQ-014 The bound tables SHALL be, for step 0..5: max = 15,15,10,10,5,5; min = 0,5,5,0,0,0.
- Even steps are UP phases and end at max.
- Odd steps are DOWN phases and end at min.
REQ-015 STOP: the state after reset; it SHALL move to IDLE on the first clock after rst deasserts.
REQ-016 IDLE:
- level 0 with flick=0 -> stay in IDLE.
- level 1 with flick=1 -> UP, step 0.
- level 0 with flick=1 -> stay in IDLE, no error.
- any other value -> error.
REQ-017 UP, level = prev+1 and below max: stay in UP.
REQ-018 UP, level reaches max[step]: pulse seg_done.
- step < 5 -> DOWN, step+1; the next level SHALL be max-1.
- step = 5 -> IDLE, pulse seq_done.
REQ-019 DOWN, level = prev-1: stay in DOWN.
REQ-020 DOWN, level reaches min[step]: pulse seg_done.
- step < 5 -> UP, step+1.
- step = 5 -> IDLE, step 0, pulse seq_done.
REQ-021 Kickback: in DOWN, prev level is 0 or 5, flick=1 and level = prev+1 -> UP, step-1, no seg_done pulse.
- step 0 SHALL saturate at 0.
- A kickback SHALL take priority over a REQ-020 reversal on the same edge.
REQ-022 NOT_THERMO error: LED is not a thermometer code, or LED = 16'hFFFF.
REQ-023 JUMP error: |level - prev| > 1.
REQ-024 BAD_HOLD error: level unchanged while in UP or DOWN, or a direction reversal that is not at a bound and is not a kickback.
REQ-025 On any error the block SHALL pulse err, update err_code, move to IDLE with step 0, and not re-arm until level 0 has been seen.
- Priority: NOT_THERMO > JUMP > BAD_HOLD.
REQ-026 The previous level SHALL be stored every cycle, including in error cycles; for NOT_THERMO the stored value is 0.
REQ-027 Step arithmetic SHALL be 3-bit and never wrap: increments stop at 5, decrements stop at 0.

Reset
REQ-028 While rst is high, all outputs and internal registers SHALL be held at their reset values regardless of clk.
REQ-029 Reset values: phase STOP, level 0, step 0, prev level 0, seg_done 0, seq_done 0, err 0, err_code 00.
REQ-030 A reset asserted mid-sequence SHALL abort it with no seq_done pulse.

Structure
REQ-031 A shared package bound_pkg SHALL hold:
- phase encodings STOP, IDLE, UP, DOWN;
- MAX_STEP = 5;
- the max and min bound tables;
- the err_code constants.
REQ-032 The block SHALL contain one sub-module, thermo_decode: 16-bit LED in, 4-bit level and 1-bit valid out, purely combinational.

Verification
REQ-033 Full sequence: after reset, flick=1 with LED=16'h0001, then a legal profile 1..15, 14..5, 6..10, 9..0, 1..5, 4..0 -> five seg_done pulses, one seq_done, phase returns to IDLE, err never asserts.
REQ-034 Kickback: in step 3 at LED=16'h001F (level 5), flick=1 and LED=16'h003F -> phase UP, step 2, no err; the sequence then climbs to 10.
REQ-035 Corrupt bar: LED=16'h0005 in UP -> err=1, err_code=01, phase IDLE; no re-arm until LED=0.
REQ-036 Jump: level 3 followed by level 5 -> err=1, err_code=10.
REQ-037 Stall: in DOWN step 1, level 8 held for two cycles -> err=1, err_code=11.
REQ-038 Reset mid-operation: rst asserted at step 2, level 7 -> all outputs at reset values immediately, no seq_done; STOP then IDLE after release.

Source files
------------

// File: rtl/bound_pkg.sv
// ---------------------------------------------------------------------------
// bound_pkg
// Shared definitions for the LED bar bound monitor: monitor phase encodings,
// the last step index, the per-step upper/lower bound tables and the error
// cause codes reported on err_code.
// ---------------------------------------------------------------------------
package bound_pkg;

    typedef enum logic [1:0] {
        PH_STOP = 2'b00,
        PH_IDLE = 2'b01,
        PH_UP   = 2'b10,
        PH_DOWN = 2'b11
    } phase_e;

    localparam logic [2:0] MAX_STEP = 3'd5;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_NOT_THERMO = 2'b01;
    localparam logic [1:0] ERR_JUMP       = 2'b10;
    localparam logic [1:0] ERR_BAD_HOLD   = 2'b11;

    // Upper bound per step: 15,15,10,10,5,5 (even steps climb to it).
    function automatic logic [3:0] bound_max(input logic [2:0] s);
        logic [3:0] r;
        case (s)
            3'd0:    r = 4'd15;
            3'd1:    r = 4'd15;
            3'd2:    r = 4'd10;
            3'd3:    r = 4'd10;
            3'd4:    r = 4'd5;
            3'd5:    r = 4'd5;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    // Lower bound per step: 0,5,5,0,0,0 (odd steps descend to it).
    function automatic logic [3:0] bound_min(input logic [2:0] s);
        logic [3:0] r;
        case (s)
            3'd1:    r = 4'd5;
            3'd2:    r = 4'd5;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/thermo_decode.sv
// ---------------------------------------------------------------------------
// thermo_decode
// Combinational decoder for a 16-LED thermometer bar.
//   led   [15:0] in  : bar pattern, legal values are 2^L-1 for L = 0..15
//   level [3:0]  out : lit-LED count L (0 when the pattern is illegal)
//   valid        out : 1 when led is a legal thermometer code
// An all-ones bar (L = 16) does not fit the 4-bit level and is illegal.
// ---------------------------------------------------------------------------
module thermo_decode (
    input  logic [15:0] led,
    output logic [3:0]  level,
    output logic        valid
);

    always_comb begin
        level = 4'd0;
        valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (led == 16'((32'd1 << i) - 32'd1)) begin
                level = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bound_monitor.sv
// ---------------------------------------------------------------------------
// bound_monitor
// Watches an LED bar driver and checks that the bar follows the up/down
// bound profile of a six-step sequence, reporting reversals, completion and
// protocol violations.
//   clk       in  : rising-edge clock shared with the bar driver
//   rst       in  : asynchronous active-high reset
//   LED[15:0] in  : observed bar (thermometer code)
//   flick     in  : flick request seen by the driver
//   level[3:0]out : registered decoded level
//   phase[1:0]out : STOP / IDLE / UP / DOWN
//   step[2:0] out : current step index 0..5
//   seg_done  out : pulse on a bound reversal
//   seq_done  out : pulse when step 5 reaches level 0
//   err       out : pulse on a protocol violation
//   err_code  out : cause of the last error (held)
// ---------------------------------------------------------------------------
module bound_monitor
    import bound_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] LED,
    input  logic        flick,
    output logic [3:0]  level,
    output logic [1:0]  phase,
    output logic [2:0]  step,
    output logic        seg_done,
    output logic        seq_done,
    output logic        err,
    output logic [1:0]  err_code
);

    function automatic logic [2:0] step_inc(input logic [2:0] s);
        return (s >= MAX_STEP) ? MAX_STEP : s + 3'd1;
    endfunction

    function automatic logic [2:0] step_dec(input logic [2:0] s);
        return (s == 3'd0) ? 3'd0 : s - 3'd1;
    endfunction

    logic [3:0] dec_level;
    logic       dec_valid;

    thermo_decode u_thermo_decode (
        .led   (LED),
        .level (dec_level),
        .valid (dec_valid)
    );

    phase_e     phase_q, phase_d;
    logic [2:0] step_q, step_d;
    logic [3:0] level_q, level_d;   // doubles as the previous level
    logic       seg_done_q, seg_done_d;
    logic       seq_done_q, seq_done_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;
    logic       rearm_wait_q, rearm_wait_d;

    logic signed [4:0] delta;
    logic              is_up, is_down, is_hold, is_zero;
    logic [1:0]        cause;
    logic [1:0]        fault;

    always_comb begin
        delta   = $signed({1'b0, dec_level}) - $signed({1'b0, level_q});
        is_up   = (delta == 5'sd1);
        is_down = (delta == -5'sd1);
        is_hold = (delta == 5'sd0);
        is_zero = dec_valid && (dec_level == 4'd0);

        // Error classification if the current sample turns out to be illegal.
        if (!dec_valid) begin
            cause = ERR_NOT_THERMO;
        end else if (!(is_up || is_down || is_hold)) begin
            cause = ERR_JUMP;
        end else begin
            cause = ERR_BAD_HOLD;
        end
    end

    always_comb begin
        phase_d      = phase_q;
        step_d       = step_q;
        level_d      = dec_level;   // decoder already yields 0 for illegal bars
        seg_done_d   = 1'b0;
        seq_done_d   = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        rearm_wait_d = rearm_wait_q;
        fault        = ERR_NONE;

        case (phase_q)
            PH_STOP: begin
                phase_d = PH_IDLE;
            end

            PH_IDLE: begin
                if (rearm_wait_q) begin
                    // After an error everything is ignored until the bar clears.
                    if (is_zero) begin
                        rearm_wait_d = 1'b0;
                    end
                end else if (is_zero) begin
                    phase_d = PH_IDLE;
                end else if (dec_valid && (dec_level == 4'd1) && flick) begin
                    phase_d = PH_UP;
                    step_d  = 3'd0;
                end else begin
                    fault = cause;
                end
            end

            PH_UP: begin
                if (!dec_valid || !is_up) begin
                    fault = cause;
                end else if (dec_level == bound_max(step_q)) begin
                    if (step_q < MAX_STEP) begin
                        seg_done_d = 1'b1;
                        phase_d    = PH_DOWN;
                        step_d     = step_inc(step_q);
                    end else begin
                        seq_done_d = 1'b1;
                        phase_d    = PH_IDLE;
                        step_d     = 3'd0;
                    end
                end else if (dec_level > bound_max(step_q)) begin
                    fault = ERR_BAD_HOLD;
                end
            end

            PH_DOWN: begin
                if (!dec_valid || !(is_up || is_down)) begin
                    fault = cause;
                end else if (is_up) begin
                    // Kickback: a flick at level 0 or 5 sends the bar back up
                    // into the previous step without counting a reversal.
                    if (flick && ((level_q == 4'd0) || (level_q == 4'd5))) begin
                        phase_d = PH_UP;
                        step_d  = step_dec(step_q);
                    end else begin
                        fault = ERR_BAD_HOLD;
                    end
                end else if (dec_level == bound_min(step_q)) begin
                    if (step_q < MAX_STEP) begin
                        seg_done_d = 1'b1;
                        phase_d    = PH_UP;
                        step_d     = step_inc(step_q);
                    end else begin
                        seq_done_d = 1'b1;
                        phase_d    = PH_IDLE;
                        step_d     = 3'd0;
                    end
                end else if (dec_level < bound_min(step_q)) begin
                    fault = ERR_BAD_HOLD;
                end
            end

            default: begin
                phase_d = PH_IDLE;
            end
        endcase

        if (fault != ERR_NONE) begin
            err_d        = 1'b1;
            err_code_d   = fault;
            phase_d      = PH_IDLE;
            step_d       = 3'd0;
            seg_done_d   = 1'b0;
            seq_done_d   = 1'b0;
            rearm_wait_d = !is_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= PH_STOP;
            step_q       <= 3'd0;
            level_q      <= 4'd0;
            seg_done_q   <= 1'b0;
            seq_done_q   <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            rearm_wait_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            step_q       <= step_d;
            level_q      <= level_d;
            seg_done_q   <= seg_done_d;
            seq_done_q   <= seq_done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            rearm_wait_q <= rearm_wait_d;
        end
    end

    assign level    = level_q;
    assign phase    = phase_q;
    assign step     = step_q;
    assign seg_done = seg_done_q;
    assign seq_done = seq_done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_bound_monitor.sv
// ---------------------------------------------------------------------------
// tb_bound_monitor
// Directed bench for bound_monitor: reset state, full legal sequence,
// table-driven idle/error/re-arm vectors, stall, kickback and mid-run reset.
// ---------------------------------------------------------------------------
module tb_bound_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] LED;
    logic        flick;
    logic [3:0]  level;
    logic [1:0]  phase;
    logic [2:0]  step;
    logic        seg_done;
    logic        seq_done;
    logic        err;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] S_STOP = 2'b00;
    localparam logic [1:0] S_IDLE = 2'b01;
    localparam logic [1:0] S_UP   = 2'b10;
    localparam logic [1:0] S_DOWN = 2'b11;

    bound_monitor dut (
        .clk      (clk),
        .rst      (rst),
        .LED      (LED),
        .flick    (flick),
        .level    (level),
        .phase    (phase),
        .step     (step),
        .seg_done (seg_done),
        .seq_done (seq_done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] led;
        logic        flick;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[26];

    // {level, phase, step, seg_done, seq_done, err, err_code}
    function automatic logic [14:0] pk(input int lv, input logic [1:0] ph, input int st,
                                       input logic sg, input logic sq, input logic er,
                                       input logic [1:0] cd);
        return {4'(lv), ph, 3'(st), sg, sq, er, cd};
    endfunction

    function automatic logic [15:0] therm(input int l);
        logic [31:0] t;
        t = (32'd1 << l) - 32'd1;
        return t[15:0];
    endfunction

    function automatic logic [14:0] observed();
        return {level, phase, step, seg_done, seq_done, err, err_code};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic [15:0] l, input logic f);
        LED   = l;
        flick = f;
        @(posedge clk);
        #1;
    endtask

    task automatic ramp(input int from, input int to);
        int v;
        int errs;
        v    = from;
        errs = 0;
        while (1) begin
            tick(therm(v), 1'b0);
            if (err) errs++;
            if (v == to) break;
            v += (to > from) ? 1 : -1;
        end
        check("ramp_no_err", errs, 0);
    endtask

    initial begin
        int seg_start[6];
        int seg_end[6];
        int seg_cnt;
        int seq_cnt;
        int err_cnt;
        int v;
        int dir;
        logic [1:0] ph;
        logic [14:0] e;

        rst   = 1'b1;
        LED   = 16'h0000;
        flick = 1'b0;

        // Reset state held across clocks
        @(posedge clk); @(posedge clk); #1;
        check("reset_state", observed(), pk(0, S_STOP, 0, 0, 0, 0, 2'b00));
        rst = 1'b0;
        #1;
        check("stop_after_release", phase, S_STOP);
        tick(16'h0000, 1'b0);
        check("idle_after_stop", observed(), pk(0, S_IDLE, 0, 0, 0, 0, 2'b00));

        // Full legal sequence
        tick(16'h0001, 1'b1);
        check("seq_start", observed(), pk(1, S_UP, 0, 0, 0, 0, 2'b00));
        seg_start = '{2, 14, 6, 9, 1, 4};
        seg_end   = '{15, 5, 10, 0, 5, 0};
        seg_cnt = 0; seq_cnt = 0; err_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            dir = (seg_end[k] > seg_start[k]) ? 1 : -1;
            v   = seg_start[k];
            while (1) begin
                tick(therm(v), 1'b0);
                if (seg_done) seg_cnt++;
                if (seq_done) seq_cnt++;
                if (err) err_cnt++;
                if (v == seg_end[k]) begin
                    if (k < 5) begin
                        ph = ((k + 1) % 2 == 0) ? S_UP : S_DOWN;
                        e  = pk(v, ph, k + 1, 1, 0, 0, 2'b00);
                    end else begin
                        e  = pk(v, S_IDLE, 0, 0, 1, 0, 2'b00);
                    end
                end else begin
                    ph = (k % 2 == 0) ? S_UP : S_DOWN;
                    e  = pk(v, ph, k, 0, 0, 0, 2'b00);
                end
                check($sformatf("seq_k%0d_l%0d", k, v), observed(), e);
                if (v == seg_end[k]) break;
                v += dir;
            end
        end
        check("seq_seg_count", seg_cnt, 5);
        check("seq_seq_count", seq_cnt, 1);
        check("seq_err_count", err_cnt, 0);

        // Table: idle rules, re-arm, jump, corrupt bar, reversal off-bound
        vecs[0]  = '{16'h0000, 1'b0, pk(0, S_IDLE, 0, 0, 0, 0, 2'b00)};
        vecs[1]  = '{16'h0000, 1'b1, pk(0, S_IDLE, 0, 0, 0, 0, 2'b00)};
        vecs[2]  = '{16'h0001, 1'b0, pk(1, S_IDLE, 0, 0, 0, 1, 2'b11)};
        vecs[3]  = '{16'h0003, 1'b1, pk(2, S_IDLE, 0, 0, 0, 0, 2'b11)};
        vecs[4]  = '{16'h0001, 1'b1, pk(1, S_IDLE, 0, 0, 0, 0, 2'b11)};
        vecs[5]  = '{16'h0000, 1'b0, pk(0, S_IDLE, 0, 0, 0, 0, 2'b11)};
        vecs[6]  = '{16'h0001, 1'b1, pk(1, S_UP,   0, 0, 0, 0, 2'b11)};
        vecs[7]  = '{16'h0003, 1'b0, pk(2, S_UP,   0, 0, 0, 0, 2'b11)};
        vecs[8]  = '{16'h0007, 1'b0, pk(3, S_UP,   0, 0, 0, 0, 2'b11)};
        vecs[9]  = '{16'h001F, 1'b0, pk(5, S_IDLE, 0, 0, 0, 1, 2'b10)};
        vecs[10] = '{16'h0001, 1'b1, pk(1, S_IDLE, 0, 0, 0, 0, 2'b10)};
        vecs[11] = '{16'h0000, 1'b0, pk(0, S_IDLE, 0, 0, 0, 0, 2'b10)};
        vecs[12] = '{16'h0001, 1'b1, pk(1, S_UP,   0, 0, 0, 0, 2'b10)};
        vecs[13] = '{16'h0003, 1'b0, pk(2, S_UP,   0, 0, 0, 0, 2'b10)};
        vecs[14] = '{16'h0005, 1'b0, pk(0, S_IDLE, 0, 0, 0, 1, 2'b01)};
        vecs[15] = '{16'h0001, 1'b1, pk(1, S_IDLE, 0, 0, 0, 0, 2'b01)};
        vecs[16] = '{16'h0000, 1'b0, pk(0, S_IDLE, 0, 0, 0, 0, 2'b01)};
        vecs[17] = '{16'h0001, 1'b1, pk(1, S_UP,   0, 0, 0, 0, 2'b01)};
        vecs[18] = '{16'hFFFF, 1'b0, pk(0, S_IDLE, 0, 0, 0, 1, 2'b01)};
        vecs[19] = '{16'h0000, 1'b0, pk(0, S_IDLE, 0, 0, 0, 0, 2'b01)};
        vecs[20] = '{16'h0007, 1'b1, pk(3, S_IDLE, 0, 0, 0, 1, 2'b10)};
        vecs[21] = '{16'h0000, 1'b0, pk(0, S_IDLE, 0, 0, 0, 0, 2'b10)};
        vecs[22] = '{16'h0001, 1'b1, pk(1, S_UP,   0, 0, 0, 0, 2'b10)};
        vecs[23] = '{16'h0003, 1'b0, pk(2, S_UP,   0, 0, 0, 0, 2'b10)};
        vecs[24] = '{16'h0001, 1'b0, pk(1, S_IDLE, 0, 0, 0, 1, 2'b11)};
        vecs[25] = '{16'h0000, 1'b0, pk(0, S_IDLE, 0, 0, 0, 0, 2'b11)};
        for (int i = 0; i < 26; i++) begin
            tick(vecs[i].led, vecs[i].flick);
            check($sformatf("vec%0d", i), observed(), vecs[i].exp);
        end

        // Stall: level 8 held in DOWN step 1
        tick(16'h0001, 1'b1);
        ramp(2, 15);
        ramp(14, 8);
        check("stall_pre", observed(), pk(8, S_DOWN, 1, 0, 0, 0, 2'b11));
        tick(16'h0000, 1'b0);   // drops 8 -> 0: jump, clears error code to 10
        check("stall_jump", observed(), pk(0, S_IDLE, 0, 0, 0, 1, 2'b10));
        tick(16'h0001, 1'b1);
        ramp(2, 15);
        ramp(14, 8);
        tick(therm(8), 1'b0);
        check("stall_hold", observed(), pk(8, S_IDLE, 0, 0, 0, 1, 2'b11));
        tick(16'h0000, 1'b0);

        // Kickback from step 3 at level 5
        tick(16'h0001, 1'b1);
        ramp(2, 15);
        ramp(14, 5);
        ramp(6, 10);
        ramp(9, 5);
        check("kick_pre", observed(), pk(5, S_DOWN, 3, 0, 0, 0, 2'b11));
        tick(16'h003F, 1'b1);
        check("kick_up", observed(), pk(6, S_UP, 2, 0, 0, 0, 2'b11));
        ramp(7, 9);
        tick(therm(10), 1'b0);
        check("kick_climb", observed(), pk(10, S_DOWN, 3, 1, 0, 0, 2'b11));
        tick(therm(9), 1'b0);
        tick(therm(10), 1'b1);
        check("kick_not_at_5", observed(), pk(10, S_IDLE, 0, 0, 0, 1, 2'b11));
        tick(16'h0000, 1'b0);

        // Reset mid-operation at step 2, level 7
        tick(16'h0001, 1'b1);
        ramp(2, 15);
        ramp(14, 5);
        ramp(6, 7);
        check("rst_pre", observed(), pk(7, S_UP, 2, 0, 0, 0, 2'b11));
        #2 rst = 1'b1;
        #1;
        check("rst_async", observed(), pk(0, S_STOP, 0, 0, 0, 0, 2'b00));
        seq_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick(therm(8 + i), 1'b0);
            if (seq_done) seq_cnt++;
        end
        check("rst_no_seq", seq_cnt, 0);
        check("rst_held", observed(), pk(0, S_STOP, 0, 0, 0, 0, 2'b00));
        LED = 16'h0000;
        rst = 1'b0;
        #1;
        check("rst_release_stop", phase, S_STOP);
        tick(16'h0000, 1'b0);
        check("rst_release_idle", observed(), pk(0, S_IDLE, 0, 0, 0, 0, 2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
